// File: rtl/unidade_controle.sv
// unidade_controle: Moore sequencer for the LED-matrix game.
// It clears the level counter, reloads the matrix, advances through the
// levels with a timed pause between them, and flags the end of the game.
module unidade_controle #(
  parameter int unsigned PAUSA_CICLOS = 50000000,
  parameter int unsigned W_PAUSA      = $clog2(PAUSA_CICLOS + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       desistir,
  input  logic       nivel_concluido,
  input  logic       nivelIgualUltimoNivel,
  output logic       zeraN,
  output logic       zeraM,
  output logic       contaN,
  output logic       jogando,
  output logic       pausa,
  output logic       pronto,
  output logic       ganhou,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    PREPARACAO    = 4'b0001,
    JOGANDO       = 4'b0011,
    PAUSA         = 4'b0100,
    PROXIMO_NIVEL = 4'b0101,
    RECARREGA     = 4'b0110,
    FIM_JOGO      = 4'b0111
  } estado_t;

  // Last timer value of the pause; the exit fires here, so the timer never wraps.
  localparam logic [W_PAUSA-1:0] ULTIMO_CICLO = W_PAUSA'(PAUSA_CICLOS - 1);

  // Raw 4-bit state so that unused codes are visible on db_estado and recoverable.
  logic [3:0]         estado;
  logic [3:0]         estado_nxt;
  logic [W_PAUSA-1:0] timer;
  logic [W_PAUSA-1:0] timer_nxt;
  logic               fim_pausa_c;

  assign fim_pausa_c = (timer == ULTIMO_CICLO);
  assign db_estado   = estado;

  // Next-state and pause-timer logic; the timer only counts while staying in PAUSA.
  always_comb begin
    estado_nxt = INICIAL;
    timer_nxt  = '0;
    case (estado)
      INICIAL: begin
        if (iniciar) estado_nxt = PREPARACAO;
        else         estado_nxt = INICIAL;
      end
      PREPARACAO: estado_nxt = JOGANDO;
      JOGANDO: begin
        if (desistir)                                     estado_nxt = INICIAL;
        else if (nivel_concluido && nivelIgualUltimoNivel) estado_nxt = FIM_JOGO;
        else if (nivel_concluido)                         estado_nxt = PAUSA;
        else                                              estado_nxt = JOGANDO;
      end
      PAUSA: begin
        if (desistir) begin
          estado_nxt = INICIAL;
        end else if (fim_pausa_c) begin
          estado_nxt = PROXIMO_NIVEL;
        end else begin
          estado_nxt = PAUSA;
          timer_nxt  = timer + W_PAUSA'(1);
        end
      end
      PROXIMO_NIVEL: estado_nxt = RECARREGA;
      RECARREGA:     estado_nxt = JOGANDO;
      FIM_JOGO: begin
        if (desistir)     estado_nxt = INICIAL;
        else if (iniciar) estado_nxt = PREPARACAO;
        else              estado_nxt = FIM_JOGO;
      end
      default: estado_nxt = INICIAL;
    endcase
  end

  // State, timer and Moore outputs; outputs are registered from the next state
  // so they always match the state register with no input-to-output path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      timer   <= '0;
      zeraN   <= 1'b0;
      zeraM   <= 1'b0;
      contaN  <= 1'b0;
      jogando <= 1'b0;
      pausa   <= 1'b0;
      pronto  <= 1'b0;
      ganhou  <= 1'b0;
    end else begin
      estado  <= estado_nxt;
      timer   <= timer_nxt;
      zeraN   <= (estado_nxt == PREPARACAO);
      zeraM   <= (estado_nxt == PREPARACAO) || (estado_nxt == RECARREGA);
      contaN  <= (estado_nxt == PROXIMO_NIVEL);
      jogando <= (estado_nxt == JOGANDO);
      pausa   <= (estado_nxt == PAUSA);
      pronto  <= (estado_nxt == FIM_JOGO);
      ganhou  <= (estado_nxt == FIM_JOGO);
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a small level-counter model.
module tb_unidade_controle;

  localparam int unsigned PC = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, desistir, nivel_concluido, nivelIgualUltimoNivel;
  logic       zeraN, zeraM, contaN, jogando, pausa, pronto, ganhou;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  // Level counter model of the datapath (levels 0..5)
  int nivel = 0;
  int n_conta = 0;
  int n_pausa = 0;
  int n_conflito = 0;
  logic pausa_q = 1'b0;

  unidade_controle #(.PAUSA_CICLOS(PC)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .desistir(desistir),
    .nivel_concluido(nivel_concluido), .nivelIgualUltimoNivel(nivelIgualUltimoNivel),
    .zeraN(zeraN), .zeraM(zeraM), .contaN(contaN), .jogando(jogando),
    .pausa(pausa), .pronto(pronto), .ganhou(ganhou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign nivelIgualUltimoNivel = (nivel == 5);

  // Datapath model plus pulse/entry monitors
  always @(posedge clock) begin
    if (zeraN) nivel <= 0;
    else if (contaN) nivel <= nivel + 1;
    if (contaN) n_conta <= n_conta + 1;
    if (pausa && !pausa_q) n_pausa <= n_pausa + 1;
    if (contaN && zeraN) n_conflito <= n_conflito + 1;
    pausa_q <= pausa;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pack all 1-bit outputs: {zeraN,zeraM,contaN,jogando,pausa,pronto,ganhou}
  function automatic logic [7:0] outs();
    return {1'b0, zeraN, zeraM, contaN, jogando, pausa, pronto, ganhou};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st, input logic [7:0] o);
    check({tag, "_estado"}, {4'h0, db_estado}, {4'h0, st});
    check({tag, "_outs"}, outs(), o);
  endtask

  // Output patterns per state
  localparam logic [7:0] O_INI  = 8'b0000_0000;
  localparam logic [7:0] O_PREP = 8'b0110_0000;
  localparam logic [7:0] O_JOG  = 8'b0000_1000;
  localparam logic [7:0] O_PAU  = 8'b0000_0100;
  localparam logic [7:0] O_PROX = 8'b0001_0000;
  localparam logic [7:0] O_REC  = 8'b0010_0000;
  localparam logic [7:0] O_FIM  = 8'b0000_0011;

  task automatic start_game(input string tag);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_state({tag, "_prep"}, 4'b0001, O_PREP);
    step();
    expect_state({tag, "_jog"}, 4'b0011, O_JOG);
  endtask

  // Plays a full game with nivel_concluido held high; ends in FIM_JOGO
  task automatic play_game(input string tag);
    int c0, p0, cyc;
    start_game(tag);
    check({tag, "_nivel0"}, 8'(nivel), 8'd0);
    c0 = n_conta;
    p0 = n_pausa;
    nivel_concluido = 1'b1;
    cyc = 0;
    while (!pronto && cyc < 200) begin
      step();
      cyc++;
    end
    check({tag, "_fim_timeout"}, {7'b0, pronto}, 8'd1);
    expect_state({tag, "_fim"}, 4'b0111, O_FIM);
    step();
    step();
    expect_state({tag, "_fim_hold"}, 4'b0111, O_FIM);
    nivel_concluido = 1'b0;
    check({tag, "_n_conta"}, 8'(n_conta - c0), 8'd5);
    check({tag, "_n_pausa"}, 8'(n_pausa - p0), 8'd5);
    check({tag, "_nivel5"}, 8'(nivel), 8'd5);
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 1'b0;
    desistir = 1'b0;
    nivel_concluido = 1'b0;
    #12;
    expect_state("reset", 4'b0000, O_INI);
    reset = 1'b1;
    step();
    step();
    expect_state("idle", 4'b0000, O_INI);

    // Start sequence and one level advance
    start_game("start");
    nivel_concluido = 1'b1;
    step();
    nivel_concluido = 1'b0;
    expect_state("pausa1", 4'b0100, O_PAU);
    for (int i = 2; i <= 4; i++) begin
      step();
      expect_state($sformatf("pausa%0d", i), 4'b0100, O_PAU);
    end
    step();
    expect_state("proximo", 4'b0101, O_PROX);
    step();
    expect_state("recarrega", 4'b0110, O_REC);
    step();
    expect_state("rejoga", 4'b0011, O_JOG);
    step();
    expect_state("jog_estavel", 4'b0011, O_JOG);

    // Asynchronous reset in the middle of a pause
    nivel_concluido = 1'b1;
    step();
    nivel_concluido = 1'b0;
    step();
    check("pausa_timer1", 8'(dut.timer), 8'd1);
    #2 reset = 1'b0;
    #1;
    expect_state("rst_mid", 4'b0000, O_INI);
    check("rst_timer", 8'(dut.timer), 8'd0);
    #3 reset = 1'b1;
    step();
    step();
    expect_state("rst_idle", 4'b0000, O_INI);

    // Abort beats completion in JOGANDO
    start_game("abort_j");
    desistir = 1'b1;
    nivel_concluido = 1'b1;
    step();
    desistir = 1'b0;
    nivel_concluido = 1'b0;
    expect_state("abort_j_ini", 4'b0000, O_INI);
    step();
    expect_state("abort_j_stay", 4'b0000, O_INI);

    // Abort in PAUSA at timer=2
    start_game("abort_p");
    nivel_concluido = 1'b1;
    step();
    nivel_concluido = 1'b0;
    step();
    step();
    check("abort_p_timer2", 8'(dut.timer), 8'd2);
    expect_state("abort_p_pausa", 4'b0100, O_PAU);
    desistir = 1'b1;
    step();
    desistir = 1'b0;
    expect_state("abort_p_ini", 4'b0000, O_INI);
    check("abort_p_timer0", 8'(dut.timer), 8'd0);

    // Full game, then restart from FIM_JOGO
    play_game("game1");
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_state("restart_prep", 4'b0001, O_PREP);
    step();
    expect_state("restart_jog", 4'b0011, O_JOG);
    check("restart_nivel0", 8'(nivel), 8'd0);

    // Second game; desistir wins over iniciar in FIM_JOGO
    desistir = 1'b1;
    step();
    desistir = 1'b0;
    expect_state("g2_abort", 4'b0000, O_INI);
    play_game("game2");
    desistir = 1'b1;
    iniciar = 1'b1;
    step();
    desistir = 1'b0;
    iniciar = 1'b0;
    expect_state("fim_both", 4'b0000, O_INI);

    check("conta_zera_conflito", 8'(n_conflito), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore FSM that sequences the game datapath: clears the level counter, reloads the LED matrix, and advances levels.
- Inserts a timed pause between levels and detects end of game.
- Drives zeraN/zeraM/contaN of the datapath; consumes nivel_concluido and nivelIgualUltimoNivel from it.
- Sits beside the datapath under the top-level game module.

Parameters:
- PAUSA_CICLOS, 50000000, length of the inter-level pause in clock cycles (legal range ≥1; 1 s at 50 MHz).
- W_PAUSA, $clog2(PAUSA_CICLOS+1), width of the pause timer.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; forces INICIAL.
- iniciar  input  1  start/restart request, level-sampled.
- desistir  input  1  abort request, level-sampled.
- nivel_concluido  input  1  matrix reports current level solved.
- nivelIgualUltimoNivel  input  1  level counter equals last level (5).
- zeraN  output  1  clear level counter (high = clear on next edge).
- zeraM  output  1  reset/reload LED matrix and edge detector (high = reset).
- contaN  output  1  increment level counter.
- jogando  output  1  high in JOGANDO.
- pausa  output  1  high in PAUSA.
- pronto  output  1  high in FIM_JOGO.
- ganhou  output  1  high in FIM_JOGO (all levels solved).
- db_estado  output  4  current state code.

Behaviour:
- Moore machine: all outputs decode from the state register only. No input-to-output combinational path.
- Reset (reset=0, asynchronous):
  - state=INICIAL, timer=0.
  - All 1-bit outputs 0; db_estado=0000.
  - Applies immediately, including mid-pause or mid-level.
- States, codes, outputs and transitions:
  - INICIAL 0000: all outputs 0. iniciar=1 -> PREPARACAO; else stay.
  - PREPARACAO 0001: zeraN=1, zeraM=1. Lasts exactly 1 cycle -> JOGANDO.
  - JOGANDO 0011: jogando=1. Priority desistir > nivel_concluido:
    - desistir=1 -> INICIAL.
    - else nivel_concluido=1 and nivelIgualUltimoNivel=1 -> FIM_JOGO.
    - else nivel_concluido=1 -> PAUSA.
    - else stay. iniciar is ignored.
  - PAUSA 0100: pausa=1. desistir=1 -> INICIAL (timer cleared). Exits to PROXIMO_NIVEL on the cycle timer==PAUSA_CICLOS-1.
  - PROXIMO_NIVEL 0101: contaN=1 for exactly 1 cycle -> RECARREGA.
  - RECARREGA 0110: zeraM=1 for exactly 1 cycle, so the matrix reloads with the already-incremented level -> JOGANDO.
  - FIM_JOGO 0111: pronto=1, ganhou=1. iniciar=1 -> PREPARACAO (new game from level 0). desistir=1 -> INICIAL. If both are high, desistir wins.
  - Any unused code -> INICIAL on the next edge; db_estado shows the raw code.
- Pause timer:
  - Cleared to 0 in every state other than PAUSA.
  - Increments by 1 each cycle in PAUSA.
  - PAUSA therefore lasts exactly PAUSA_CICLOS cycles.
  - Never wraps: the exit compare fires first.
- Level sequencing:
  - contaN pulses once per solved non-final level, so a full game from level 0 produces exactly 5 contaN pulses.
  - contaN and zeraN are never high in the same cycle.
- nivel_concluido held high across several cycles must not cause double advance:
  - Only JOGANDO samples it.
  - RECARREGA reset clears it in the matrix before JOGANDO is re-entered.

Test Plan:
- Reset mid-operation:
  - Stimulus: PAUSA_CICLOS=4; enter PAUSA; drive reset=0 asynchronously between edges.
  - Required: db_estado=0000 immediately, all outputs 0, timer=0. After reset release, stays INICIAL while iniciar=0.
- Start sequence:
  - Stimulus: iniciar=1 for 1 cycle from INICIAL.
  - Required: next state PREPARACAO with zeraN=zeraM=1 for exactly 1 cycle, then JOGANDO with jogando=1.
- Level advance:
  - Stimulus: PAUSA_CICLOS=4, nivelIgualUltimoNivel=0; nivel_concluido=1 in JOGANDO.
  - Required, cycle by cycle:
    - PAUSA: pausa=1 for exactly 4 cycles.
    - PROXIMO_NIVEL: contaN=1 for 1 cycle.
    - RECARREGA: zeraM=1 for 1 cycle.
    - Back to JOGANDO.
- Full game:
  - Stimulus: integrate with the datapath (6 levels, 0..5); solve each level.
  - Required: exactly 5 contaN pulses. After the final nivel_concluido (nivelIgualUltimoNivel=1): FIM_JOGO, pronto=ganhou=1, no contaN.
  - Then iniciar=1 -> PREPARACAO, level counter back to 0.
- Abort priority:
  - Stimulus: in JOGANDO, desistir=1 and nivel_concluido=1 in the same cycle.
  - Required: -> INICIAL, no PAUSA entry, no contaN pulse. Repeat in PAUSA at timer=2: -> INICIAL, timer cleared.
- Held completion:
  - Stimulus: hold nivel_concluido=1 through PAUSA, PROXIMO_NIVEL and RECARREGA.
  - Required: exactly one contaN pulse per PAUSA entry.
